// File: rtl/regbank_pkg.sv
// Shared types and helpers for the register-bank arbiter and its round-robin picker.
package regbank_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RDATA} arb_state_t;

  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int MAX_MASTERS = 8;

  // First set bit of req at or after ptr, wrapping modulo n (n <= MAX_MASTERS).
  function automatic logic [MAX_MASTERS-1:0] rr_onehot(
    input logic [MAX_MASTERS-1:0] req,
    input logic [2:0]             ptr,
    input int                     n
  );
    logic [MAX_MASTERS-1:0] pick;
    int idx;
    pick = '0;
    for (int k = 0; k < MAX_MASTERS; k++) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (pick == '0 && req[idx[2:0]]) pick[idx[2:0]] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/regbank_arbiter_rr_pick.sv
// Combinational round-robin priority selector: request vector + pointer -> one-hot grant.
module rr_pick
  import regbank_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  assign grant = N'(rr_onehot(MAX_MASTERS'(req), 3'(ptr), N));

endmodule

// File: rtl/regbank_arbiter.sv
// Round-robin arbiter sequencing single read/write transactions from several
// masters onto one shared slave register bank.
module regbank_arbiter
  import regbank_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_done,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]        m_grant,
  output logic                          s_valid,
  input  logic                          s_ready,
  output logic                          s_write,
  output logic                          s_read,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic [DATA_W-1:0]             s_rdata
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_t             state;
  logic [NUM_MASTERS-1:0] grant;
  logic [NUM_MASTERS-1:0] pick;
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       gidx;
  logic [PTR_W-1:0]       ptr_next;
  logic                   req_g;
  logic                   wr_g;
  logic                   rd_g;
  logic                   is_read;

  rr_pick #(
    .N     (NUM_MASTERS),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (m_req),
    .ptr   (ptr),
    .grant (pick)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) gidx = PTR_W'(i);
    end
  end

  assign ptr_next = (gidx == PTR_W'(NUM_MASTERS - 1)) ? '0 : gidx + 1'b1;
  assign req_g    = m_req[gidx];
  assign wr_g     = m_write[gidx];
  assign rd_g     = m_read[gidx];
  // Write wins over read; neither set is a no-op that completes like a write.
  assign is_read  = rd_g & ~wr_g;
  assign m_grant  = grant;

  // Bank-side signals follow the granted master only while issuing.
  always_comb begin
    s_valid = 1'b0;
    s_write = 1'b0;
    s_read  = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    if (state == ISSUE) begin
      s_valid = 1'b1;
      s_write = wr_g;
      s_read  = is_read;
      s_addr  = m_addr[gidx*ADDR_W +: ADDR_W];
      s_wdata = m_wdata[gidx*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      grant   <= '0;
      ptr     <= '0;
      m_done  <= '0;
      m_rdata <= '0;
    end else begin
      m_done <= '0;
      case (state)
        IDLE: begin
          if (|m_req) begin
            grant <= pick;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (s_ready) begin
            if (is_read) begin
              state <= RDATA;
            end else begin
              m_done <= grant;
              ptr    <= ptr_next;
              grant  <= '0;
              state  <= IDLE;
            end
          end else if (!req_g) begin
            // Abandoned before handshake: pointer stays so this master keeps its turn.
            grant <= '0;
            state <= IDLE;
          end
        end
        RDATA: begin
          m_rdata <= s_rdata;
          m_done  <= grant;
          ptr     <= ptr_next;
          grant   <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed bench for regbank_arbiter with a behavioural 16x32 register bank.
module tb_regbank_arbiter;

  localparam int NM = 4;
  localparam int AW = 4;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [NM-1:0]    m_req;
  logic [NM-1:0]    m_write;
  logic [NM-1:0]    m_read;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM-1:0]    m_done;
  logic [DW-1:0]    m_rdata;
  logic [NM-1:0]    m_grant;
  logic             s_valid;
  logic             s_ready;
  logic             s_write;
  logic             s_read;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [DW-1:0]    s_rdata;

  logic [DW-1:0]    mem [16];

  int vectors     = 0;
  int miscompares = 0;

  regbank_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_W      (AW),
    .DATA_W      (DW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .m_req   (m_req),
    .m_write (m_write),
    .m_read  (m_read),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_done  (m_done),
    .m_rdata (m_rdata),
    .m_grant (m_grant),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_write (s_write),
    .s_read  (s_read),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_rdata (s_rdata)
  );

  always #5 clk = ~clk;

  // Slave bank: read data registered one cycle after the handshake.
  always @(posedge clk) begin
    if (s_valid && s_ready) begin
      if (s_write) mem[s_addr] <= s_wdata;
      if (s_read)  s_rdata     <= mem[s_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic rq, input logic wr, input logic rd,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_req[m]             = rq;
    m_write[m]           = wr;
    m_read[m]            = rd;
    m_addr[m*AW +: AW]   = a;
    m_wdata[m*DW +: DW]  = d;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_grant"},  64'(m_grant), 64'h0);
    chk({tag, "_done"},   64'(m_done),  64'h0);
    chk({tag, "_svalid"}, 64'(s_valid), 64'h0);
    chk({tag, "_swrite"}, 64'(s_write), 64'h0);
    chk({tag, "_sread"},  64'(s_read),  64'h0);
    chk({tag, "_saddr"},  64'(s_addr),  64'h0);
    chk({tag, "_swdata"}, 64'(s_wdata), 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    m_req   = '0;
    m_write = '0;
    m_read  = '0;
    m_addr  = '0;
    m_wdata = '0;
    s_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk_idle_outputs("rst");
    chk("rst_rdata", 64'(m_rdata), 64'h0);
    reset = 1'b1;
    tick();

    // Single write: master 1, addr 3
    set_m(1, 1'b1, 1'b1, 1'b0, 4'h3, 32'hDEADBEEF);
    tick();
    chk("wr1_grant",  64'(m_grant), 64'b0010);
    chk("wr1_svalid", 64'(s_valid), 64'h1);
    chk("wr1_swrite", 64'(s_write), 64'h1);
    chk("wr1_sread",  64'(s_read),  64'h0);
    chk("wr1_saddr",  64'(s_addr),  64'h3);
    chk("wr1_swdata", 64'(s_wdata), 64'hDEADBEEF);
    chk("wr1_nodone", 64'(m_done),  64'h0);
    tick();
    chk("wr1_done",   64'(m_done),  64'b0010);
    chk("wr1_svalid0",64'(s_valid), 64'h0);
    chk("wr1_grant0", 64'(m_grant), 64'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    tick();
    chk("wr1_done0",  64'(m_done),  64'h0);

    // Write 12345678 to addr 5 from master 2 (pointer now 2)
    set_m(2, 1'b1, 1'b1, 1'b0, 4'h5, 32'h12345678);
    tick();
    chk("wr2_grant",  64'(m_grant), 64'b0100);
    tick();
    chk("wr2_done",   64'(m_done),  64'b0100);
    set_m(2, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    tick();

    // Single read: master 0 reads addr 5 (pointer 3 wraps to 0)
    set_m(0, 1'b1, 1'b0, 1'b1, 4'h5, 32'h0);
    tick();
    chk("rd1_grant",  64'(m_grant), 64'b0001);
    chk("rd1_sread",  64'(s_read),  64'h1);
    chk("rd1_swrite", 64'(s_write), 64'h0);
    chk("rd1_saddr",  64'(s_addr),  64'h5);
    tick();
    chk("rd1_rdata_grant", 64'(m_grant), 64'b0001);
    chk("rd1_rdata_svalid",64'(s_valid), 64'h0);
    chk("rd1_rdata_nodone",64'(m_done),  64'h0);
    tick();
    chk("rd1_done",   64'(m_done),  64'b0001);
    chk("rd1_rdata",  64'(m_rdata), 64'h12345678);
    chk("rd1_grant0", 64'(m_grant), 64'h0);
    set_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    tick();

    // Read back addr 3 from master 3 (pointer 1 -> picks 3)
    set_m(3, 1'b1, 1'b0, 1'b1, 4'h3, 32'h0);
    tick();
    chk("rd2_grant",  64'(m_grant), 64'b1000);
    tick();
    tick();
    chk("rd2_done",   64'(m_done),  64'b1000);
    chk("rd2_rdata",  64'(m_rdata), 64'hDEADBEEF);
    set_m(3, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    tick();
    chk("rd2_rdata_hold", 64'(m_rdata), 64'hDEADBEEF);

    // Contention: all masters write continuously (pointer 0)
    for (int i = 0; i < NM; i++) set_m(i, 1'b1, 1'b1, 1'b0, 4'(8 + i), 32'hA0 + 32'(i));
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("cont%0d_grant", k), 64'(m_grant), 64'(4'b0001 << (k % NM)));
      chk($sformatf("cont%0d_saddr", k), 64'(s_addr),  64'(8 + (k % NM)));
      tick();
      chk($sformatf("cont%0d_done", k),  64'(m_done),  64'(4'b0001 << (k % NM)));
      if (k == 4) m_req = '0;
      tick();
    end
    for (int i = 0; i < NM; i++) set_m(i, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);

    // Write and read both set: write wins (pointer 1)
    set_m(1, 1'b1, 1'b1, 1'b1, 4'h6, 32'h5555AAAA);
    tick();
    chk("both_swrite", 64'(s_write), 64'h1);
    chk("both_sread",  64'(s_read),  64'h0);
    tick();
    chk("both_done",   64'(m_done),  64'b0010);
    set_m(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    tick();

    // Stall: s_ready low for 5 ISSUE cycles (pointer 2)
    s_ready = 1'b0;
    set_m(2, 1'b1, 1'b1, 1'b0, 4'h7, 32'hCAFEF00D);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_svalid", k), 64'(s_valid), 64'h1);
      chk($sformatf("stall%0d_saddr", k),  64'(s_addr),  64'h7);
      chk($sformatf("stall%0d_swdata", k), 64'(s_wdata), 64'hCAFEF00D);
      chk($sformatf("stall%0d_done", k),   64'(m_done),  64'h0);
      if (k < 4) tick();
    end
    s_ready = 1'b1;
    tick();
    chk("stall_done",  64'(m_done),  64'b0100);
    set_m(2, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    tick();

    // No-op: neither write nor read (pointer 3)
    set_m(3, 1'b1, 1'b0, 1'b0, 4'h2, 32'h0);
    tick();
    chk("noop_svalid", 64'(s_valid), 64'h1);
    chk("noop_swrite", 64'(s_write), 64'h0);
    chk("noop_sread",  64'(s_read),  64'h0);
    tick();
    chk("noop_done",   64'(m_done),  64'b1000);
    set_m(3, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    tick();

    // Abort: master 2 drops request while stalled (pointer 0)
    s_ready = 1'b0;
    set_m(2, 1'b1, 1'b1, 1'b0, 4'h9, 32'h0BADF00D);
    tick();
    chk("abort_grant", 64'(m_grant), 64'b0100);
    m_req[2] = 1'b0;
    tick();
    chk("abort_grant0", 64'(m_grant), 64'h0);
    chk("abort_svalid", 64'(s_valid), 64'h0);
    chk("abort_nodone", 64'(m_done),  64'h0);
    tick();
    chk("abort_nodone2", 64'(m_done), 64'h0);
    s_ready = 1'b1;
    set_m(2, 1'b1, 1'b1, 1'b0, 4'h9, 32'h0BADF00D);
    set_m(3, 1'b1, 1'b1, 1'b0, 4'hA, 32'h0);
    tick();
    chk("abort_regrant", 64'(m_grant), 64'b0100);
    tick();
    chk("abort_redone",  64'(m_done),  64'b0100);
    set_m(2, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    set_m(3, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    tick();

    // Async reset during RDATA (pointer 3)
    set_m(3, 1'b1, 1'b0, 1'b1, 4'h7, 32'h0);
    tick();
    tick();
    chk("rst_mid_grant", 64'(m_grant), 64'b1000);
    #2;
    reset = 1'b0;
    #1;
    chk_idle_outputs("rst_mid");
    chk("rst_mid_rdata", 64'(m_rdata), 64'h0);
    set_m(3, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    tick();
    chk("rst_mid_nodone", 64'(m_done), 64'h0);
    reset = 1'b1;
    set_m(1, 1'b1, 1'b0, 1'b1, 4'h8, 32'h0);
    set_m(3, 1'b1, 1'b0, 1'b1, 4'h8, 32'h0);
    tick();
    chk("post_rst_grant", 64'(m_grant), 64'b0010);
    tick();
    tick();
    chk("post_rst_done",  64'(m_done),  64'b0010);
    chk("post_rst_rdata", 64'(m_rdata), 64'hA0);
    set_m(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    set_m(3, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regbank_arbiter.md
Name: regbank_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one 16x32 slave register bank between NUM_MASTERS requesters.
- Each requester issues single read or write transactions.
- Arbiter selects one, drives the bank's valid/write/read/addr/write_data, waits for ready, and returns completion plus read data to the winner.
- Sits between master-side request logic and the slave register block on the shared bus.

Parameters:
NUM_MASTERS, 4, number of requesters (2..8)
ADDR_W, 4, register bank address width (16 entries)
DATA_W, 32, data width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous active-low reset
m_req  in  NUM_MASTERS  per-master request, held until m_done
m_write  in  NUM_MASTERS  per-master write qualifier
m_read  in  NUM_MASTERS  per-master read qualifier
m_addr  in  NUM_MASTERS*ADDR_W  packed per-master addresses, master i at [i*ADDR_W +: ADDR_W]
m_wdata  in  NUM_MASTERS*DATA_W  packed per-master write data
m_done  out  NUM_MASTERS  one-cycle completion pulse to granted master
m_rdata  out  DATA_W  read data, valid when the corresponding m_done pulses for a read
m_grant  out  NUM_MASTERS  one-hot current owner, 0 when idle
s_valid  out  1  bank transaction valid
s_ready  in  1  bank accepts transaction
s_write  out  1  bank write strobe
s_read  out  1  bank read strobe
s_addr  out  ADDR_W  bank address
s_wdata  out  DATA_W  bank write data
s_rdata  in  DATA_W  bank read data, registered one cycle after the valid&&ready handshake

Behaviour:
- Reset (async, reset=0): state=IDLE, grant=0, pointer=0.
- Reset values of outputs: m_done=0, m_rdata=0, m_grant=0, s_valid=0, s_write=0, s_read=0, s_addr=0, s_wdata=0.
- FSM has three states:
  - IDLE: if any m_req, pick first set bit at or after pointer (wrapping modulo NUM_MASTERS), register the one-hot grant, go to ISSUE. Otherwise stay.
  - ISSUE: s_valid=1. s_write, s_read, s_addr and s_wdata are muxed combinationally from the granted master.
    - If m_write and m_read are both set, the write wins: s_read=0.
    - If neither is set, the transaction is a no-op and completes like a write.
    - On s_valid&&s_ready with a write or no-op: pulse m_done[g] next cycle, set pointer=g+1 (wrap), go to IDLE.
    - On s_valid&&s_ready with a read: go to RDATA.
    - If m_req[g] drops before the handshake: abort to IDLE, no m_done, pointer unchanged.
  - RDATA: s_valid=0; capture s_rdata into m_rdata, pulse m_done[g], pointer=g+1, go to IDLE.
- Hold rules:
  - m_rdata holds its last value until the next read completes.
  - m_grant stays asserted through ISSUE and RDATA, and clears on return to IDLE.
- Latency with s_ready tied high:
  - Write: request seen in IDLE at cycle 0, handshake in cycle 1, m_done at cycle 2.
  - Read: handshake in cycle 1, RDATA in cycle 2, m_done with m_rdata at cycle 3.
- Back-to-back: IDLE always spends one cycle, so the maximum rate is one write per 2 cycles and one read per 3 cycles.
- Fairness: a continuously requesting master waits at most NUM_MASTERS-1 transactions.
- s_ready low stalls ISSUE indefinitely; all s_* outputs stay stable while stalled.
- Reset mid-transaction: everything returns to reset values immediately; an in-flight bank write may or may not have landed.
- m_done is never asserted to a master that does not own the grant.

Decomposition:
- Package regbank_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, RDATA} arb_state_t
  - ADDR_W and DATA_W defaults
  - a function returning the round-robin one-hot pick from (req, pointer)
- One sub-module, rr_pick: combinational round-robin priority selector (req vector, pointer -> one-hot grant). It is reusable for other shared bus resources.

Test Plan:
- Single write: m_req[1]=1, m_write[1]=1, addr=4'h3, wdata=32'hDEADBEEF, s_ready=1 -> s_valid high 1 cycle with addr 3; m_done[1] pulse at cycle 2; later read of addr 3 returns 32'hDEADBEEF.
- Single read: preload addr 5=32'h12345678; master 0 reads -> m_done[0] at cycle 3, m_rdata=32'h12345678, m_grant=4'b0001 during ISSUE/RDATA.
- Contention: all 4 masters request writes continuously after reset -> grant order 0,1,2,3,0, each m_done 2 cycles apart, no master served twice before the others.
- Stall: s_ready held low 5 cycles during ISSUE -> s_valid/s_addr/s_wdata stable, no m_done until the cycle after s_ready=1.
- Abort: master 2 drops m_req in ISSUE with s_ready=0 -> return to IDLE, no m_done, pointer unchanged so master 2 is next if it re-requests.
- Async reset: assert reset in RDATA -> all outputs 0 immediately, no m_done; after release, a new request is served with pointer=0.
